// File: rtl/lighthouse_pulse_capture.sv
// ---------------------------------------------------------------------------
// lighthouse_pulse_capture
//
// Measures the high-pulse duration of up to NUM_SENSORS lighthouse photodiode
// inputs in parallel. Durations are counted in ticks of an internal prescaled
// timebase. Each channel can run one-shot or auto-rearm. Results, status and
// control are accessed through an Avalon-MM slave with no wait states.
//
// Ports:
//   clock           system clock
//   reset           asynchronous, active-low reset
//   address         Avalon word address
//   write           Avalon write strobe
//   writedata       Avalon write data
//   read            Avalon read strobe (a read of a duration word clears
//                   that channel's valid flag)
//   readdata        Avalon read data, combinational from address
//   waitrequest     always 0
//   sensor_signal_i raw asynchronous sensor inputs
//
// Register map (word addresses):
//   0      R: valid bits       W: 1 arms channel i
//   1      R/W: mode bits (1 = auto-rearm)
//   2      R: free-running tick timer
//   3      R: overflow bits    W: write-1-to-clear
//   4+i    R: duration[i]
//   other  R: 32'hDEAD_BEEF
// ---------------------------------------------------------------------------
module lighthouse_pulse_capture #(
  parameter int NUM_SENSORS = 16,
  parameter int CNT_WIDTH   = 32,
  parameter int PRESCALE    = 50,
  parameter int MAX_TICKS   = 10000,
  parameter int ADDR_WIDTH  = 5
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [ADDR_WIDTH-1:0]  address,
  input  logic                   write,
  input  logic [31:0]            writedata,
  input  logic                   read,
  output logic [31:0]            readdata,
  output logic                   waitrequest,
  input  logic [NUM_SENSORS-1:0] sensor_signal_i
);

  localparam int                  PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0]     PS_LAST = PS_W'(PRESCALE - 1);
  localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_TICKS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_HIGH,
    ST_DONE
  } chState_t;

  logic [NUM_SENSORS-1:0] r_sync1;
  logic [NUM_SENSORS-1:0] r_sync2;
  logic [NUM_SENSORS-1:0] r_syncDly;
  logic [NUM_SENSORS-1:0] w_rise;
  logic [NUM_SENSORS-1:0] w_fall;

  logic [PS_W-1:0]        r_prescale;
  logic                   w_tick;
  logic [CNT_WIDTH-1:0]   r_timer;

  chState_t               r_state    [NUM_SENSORS];
  logic [CNT_WIDTH-1:0]   r_durCnt   [NUM_SENSORS];
  logic [CNT_WIDTH-1:0]   r_duration [NUM_SENSORS];
  logic [CNT_WIDTH-1:0]   w_durNext  [NUM_SENSORS];
  logic [NUM_SENSORS-1:0] r_valid;
  logic [NUM_SENSORS-1:0] r_ovf;
  logic [NUM_SENSORS-1:0] r_mode;

  logic                   w_armWr;
  logic                   w_modeWr;
  logic                   w_ovfClrWr;
  logic [NUM_SENSORS-1:0] w_rdClr;
  logic                   w_unused;

  assign waitrequest = 1'b0;
  assign w_unused    = &{1'b0, writedata[31:NUM_SENSORS]};

  // Two flops resynchronise the asynchronous pins; the third holds the
  // previous synchronised level so edges can be detected.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_syncDly <= '0;
    end else begin
      r_sync1   <= sensor_signal_i;
      r_sync2   <= r_sync1;
      r_syncDly <= r_sync2;
    end
  end

  assign w_rise = r_sync2 & ~r_syncDly;
  assign w_fall = ~r_sync2 & r_syncDly;

  // Prescaler wraps at PRESCALE-1; with PRESCALE=1 it stays at 0 and the
  // tick is asserted every clock.
  assign w_tick = (r_prescale == PS_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_prescale <= '0;
      r_timer    <= '0;
    end else begin
      if (w_tick) begin
        r_prescale <= '0;
        r_timer    <= r_timer + 1'b1;
      end else begin
        r_prescale <= r_prescale + 1'b1;
      end
    end
  end

  assign w_armWr    = write && (address == ADDR_WIDTH'(0));
  assign w_modeWr   = write && (address == ADDR_WIDTH'(1));
  assign w_ovfClrWr = write && (address == ADDR_WIDTH'(3));

  // Per-channel read-clear strobes and the tick-advanced duration count.
  always_comb begin
    for (int i = 0; i < NUM_SENSORS; i++) begin
      w_rdClr[i]   = read && (address == ADDR_WIDTH'(i + 4));
      w_durNext[i] = r_durCnt[i] + {{(CNT_WIDTH-1){1'b0}}, w_tick};
    end
  end

  // Channel FSMs and status flags. An arm write overrides everything else
  // on that channel. Inside the FSM branch, later assignments deliberately
  // win: a capture beats a read-clear, a timeout beats an overflow clear.
  // The fall latches the tick-advanced count so a pulse seen high for N
  // ticks reports N.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_SENSORS; i++) begin
        r_state[i]    <= ST_IDLE;
        r_durCnt[i]   <= '0;
        r_duration[i] <= '0;
      end
      r_valid <= '0;
      r_ovf   <= '0;
      r_mode  <= '0;
    end else begin
      if (w_modeWr) begin
        r_mode <= writedata[NUM_SENSORS-1:0];
      end
      for (int i = 0; i < NUM_SENSORS; i++) begin
        if (w_armWr && writedata[i]) begin
          r_state[i]  <= ST_ARMED;
          r_durCnt[i] <= '0;
          r_valid[i]  <= 1'b0;
          r_ovf[i]    <= 1'b0;
        end else begin
          if (w_rdClr[i]) begin
            r_valid[i] <= 1'b0;
          end
          if (w_ovfClrWr && writedata[i]) begin
            r_ovf[i] <= 1'b0;
          end
          case (r_state[i])
            ST_IDLE: begin
              r_state[i] <= ST_IDLE;
            end
            ST_ARMED: begin
              if (w_rise[i]) begin
                r_state[i]  <= ST_HIGH;
                r_durCnt[i] <= '0;
              end
            end
            ST_HIGH: begin
              if (w_fall[i]) begin
                r_duration[i] <= w_durNext[i];
                r_valid[i]    <= 1'b1;
                r_state[i]    <= ST_DONE;
              end else if (w_durNext[i] >= MAX_CNT) begin
                r_duration[i] <= MAX_CNT;
                r_valid[i]    <= 1'b1;
                r_ovf[i]      <= 1'b1;
                r_state[i]    <= ST_DONE;
              end else begin
                r_durCnt[i] <= w_durNext[i];
              end
            end
            ST_DONE: begin
              r_state[i] <= r_mode[i] ? ST_ARMED : ST_IDLE;
            end
            default: begin
              r_state[i] <= ST_IDLE;
            end
          endcase
        end
      end
    end
  end

  // Read mux is purely address-driven; the read strobe only matters for
  // the valid-clear side effect.
  always_comb begin
    readdata = 32'hDEAD_BEEF;
    case (address)
      ADDR_WIDTH'(0): readdata = 32'(r_valid);
      ADDR_WIDTH'(1): readdata = 32'(r_mode);
      ADDR_WIDTH'(2): readdata = 32'(r_timer);
      ADDR_WIDTH'(3): readdata = 32'(r_ovf);
      default: begin
        for (int i = 0; i < NUM_SENSORS; i++) begin
          if (address == ADDR_WIDTH'(i + 4)) begin
            readdata = 32'(r_duration[i]);
          end
        end
      end
    endcase
  end

endmodule
